// File: rtl/udp_payload_ram_ctrl_if.sv
// Bundle of every non-clock signal of udp_payload_ram_ctrl.
// slave  : the controller side (takes ROM data, RX strobes and reload; drives RAM port A and TX lengths).
// master : the environment side (message ROM, UDP receive path, RAM port A and UDP transmitter).
interface udp_payload_ram_ctrl_if #(
    parameter int ADDR_W = 9
);
    // control
    logic              reload;
    // message ROM
    logic [ADDR_W-1:0] msg_rd_addr;
    logic [31:0]       msg_rd_data;
    // UDP receive path
    logic              rx_busy;
    logic              rx_wr_en;
    logic [ADDR_W-1:0] rx_wr_addr;
    logic [31:0]       rx_wr_data;
    logic              rx_pkt_done;
    logic [15:0]       rx_data_length;
    logic [15:0]       rx_total_length;
    // RAM write port A
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    // status and TX lengths
    logic              init_done;
    logic              data_receive;
    logic [15:0]       tx_data_length;
    logic [15:0]       tx_total_length;
    logic [7:0]        drop_cnt;

    modport slave (
        input  reload, msg_rd_data,
        input  rx_busy, rx_wr_en, rx_wr_addr, rx_wr_data,
        input  rx_pkt_done, rx_data_length, rx_total_length,
        output msg_rd_addr,
        output ram_we, ram_addr, ram_din,
        output init_done, data_receive, tx_data_length, tx_total_length, drop_cnt
    );

    modport master (
        output reload, msg_rd_data,
        output rx_busy, rx_wr_en, rx_wr_addr, rx_wr_data,
        output rx_pkt_done, rx_data_length, rx_total_length,
        input  msg_rd_addr,
        input  ram_we, ram_addr, ram_din,
        input  init_done, data_receive, tx_data_length, tx_total_length, drop_cnt
    );
endinterface

// File: rtl/udp_payload_ram_ctrl.sv
// Owner of UDP payload RAM write port A: seeds the default message from a ROM, then forwards RX writes.
// Latency: RX write -> RAM port 1 cycle; first seed write 2 cycles after reset/re-arm; lengths 1 cycle after pkt_done.
// Backpressure: none; RX strobes arriving while the port is seeding are discarded and counted in drop_cnt.
//
// Ports: clk (GMII RX clock), reset (async, active-high), bus (udp_payload_ram_ctrl_if.slave):
//   reload / msg_rd_addr / msg_rd_data        - re-arm request and registered message ROM
//   rx_busy / rx_wr_* / rx_pkt_done / rx_*_len - UDP receive path
//   ram_we / ram_addr / ram_din               - RAM port A
//   init_done / data_receive / tx_*_length / drop_cnt - status towards the UDP transmitter
module udp_payload_ram_ctrl #(
    parameter int ADDR_W    = 9,
    parameter int MSG_WORDS = 5,
    parameter int MSG_BYTES = 20,
    parameter int INIT_BASE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    udp_payload_ram_ctrl_if.slave bus
);

    localparam logic [1:0] S_INIT      = 2'd0;
    localparam logic [1:0] S_DRAIN     = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;
    localparam logic [1:0] S_WAIT_IDLE = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(INIT_BASE);
    localparam logic [15:0]       DEF_DLEN = 16'(MSG_BYTES + 8);   // UDP header adds 8 bytes
    localparam logic [15:0]       DEF_TLEN = 16'(MSG_BYTES + 28);  // plus 20-byte IP header

    // The whole message must fit above INIT_BASE without the address wrapping.
    generate
        if (MSG_WORDS < 1 || (INIT_BASE + MSG_WORDS - 1) > ((1 << ADDR_W) - 1)) begin : g_bad_params
            $error("udp_payload_ram_ctrl: INIT_BASE+MSG_WORDS-1 must fit in ADDR_W bits and MSG_WORDS>=1");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_vld;   // ROM output holds word r_rd_idx this cycle
    logic [ADDR_W-1:0] r_rd_idx;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_din;
    logic              r_init_done;
    logic              r_data_receive;
    logic [15:0]       r_tx_dlen;
    logic [15:0]       r_tx_tlen;
    logic [7:0]        r_drop_cnt;

    logic w_fwd;    // RX path owns the port (RUN, and WAIT_IDLE while the packet finishes)
    logic w_rearm;  // restart seeding this cycle

    assign w_fwd   = (r_state == S_RUN) || (r_state == S_WAIT_IDLE);
    assign w_rearm = ((r_state == S_RUN) && bus.reload && !bus.rx_busy) ||
                     ((r_state == S_WAIT_IDLE) && !bus.rx_busy);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_INIT;
            r_rd_addr      <= '0;
            r_rd_vld       <= 1'b0;
            r_rd_idx       <= '0;
            r_ram_we       <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_din      <= '0;
            r_init_done    <= 1'b0;
            r_data_receive <= 1'b0;
            r_tx_dlen      <= DEF_DLEN;
            r_tx_tlen      <= DEF_TLEN;
            r_drop_cnt     <= '0;
        end else begin
            // RAM port A mux: RX path when it owns the port, otherwise the delayed ROM stream.
            if (w_fwd) begin
                r_ram_we   <= bus.rx_wr_en;
                r_ram_addr <= bus.rx_wr_addr;
                r_ram_din  <= bus.rx_wr_data;
            end else begin
                r_ram_we   <= r_rd_vld;
                r_ram_addr <= BASE + r_rd_idx;
                r_ram_din  <= bus.msg_rd_data;
            end

            if (!w_fwd && bus.rx_wr_en && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;

            // A re-arm takes priority over a packet completing in the same cycle.
            if (w_rearm) begin
                r_data_receive <= 1'b0;
                r_tx_dlen      <= DEF_DLEN;
                r_tx_tlen      <= DEF_TLEN;
            end else if (w_fwd && bus.rx_pkt_done) begin
                r_data_receive <= 1'b1;
                r_tx_dlen      <= bus.rx_data_length;
                r_tx_tlen      <= bus.rx_total_length;
            end

            case (r_state)
                S_INIT: begin
                    // The ROM samples r_rd_addr on this edge; its data is written next cycle.
                    r_rd_vld <= 1'b1;
                    r_rd_idx <= r_rd_addr;
                    if (r_rd_addr == LAST_IDX)
                        r_state <= S_DRAIN;
                    else
                        r_rd_addr <= r_rd_addr + 1'b1;
                end
                S_DRAIN: begin
                    // First cycle writes the final word; the following one hands over the port.
                    r_rd_vld <= 1'b0;
                    if (!r_rd_vld) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.reload) begin
                        if (bus.rx_busy) begin
                            r_state <= S_WAIT_IDLE;
                        end else begin
                            r_state     <= S_INIT;
                            r_rd_addr   <= '0;
                            r_rd_vld    <= 1'b0;
                            r_init_done <= 1'b0;
                        end
                    end
                end
                default: begin  // S_WAIT_IDLE
                    if (!bus.rx_busy) begin
                        r_state     <= S_INIT;
                        r_rd_addr   <= '0;
                        r_rd_vld    <= 1'b0;
                        r_init_done <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.msg_rd_addr     = r_rd_addr;
    assign bus.ram_we          = r_ram_we;
    assign bus.ram_addr        = r_ram_addr;
    assign bus.ram_din         = r_ram_din;
    assign bus.init_done       = r_init_done;
    assign bus.data_receive    = r_data_receive;
    assign bus.tx_data_length  = r_tx_dlen;
    assign bus.tx_total_length = r_tx_tlen;
    assign bus.drop_cnt        = r_drop_cnt;

endmodule

// File: tb/tb_udp_payload_ram_ctrl.sv
// Bench for udp_payload_ram_ctrl: instance A uses default parameters, instance B a 300-word message.
// Expected RAM writes are queued when stimulus is driven and compared by a monitor on every write.
module tb_udp_payload_ram_ctrl;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   errors;
    int   checks;
    wr_t  qa[$];
    wr_t  qb[$];
    logic [31:0] rom_a [0:4];

    udp_payload_ram_ctrl_if #(.ADDR_W(9)) a_if ();
    udp_payload_ram_ctrl_if #(.ADDR_W(9)) b_if ();

    udp_payload_ram_ctrl #(.ADDR_W(9), .MSG_WORDS(5), .MSG_BYTES(20), .INIT_BASE(1)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (a_if)
    );

    udp_payload_ram_ctrl #(.ADDR_W(9), .MSG_WORDS(300), .MSG_BYTES(1200), .INIT_BASE(1)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered message ROMs: data valid one cycle after the address.
    always @(posedge clk) a_if.msg_rd_data <= rom_a[a_if.msg_rd_addr];
    always @(posedge clk) b_if.msg_rd_data <= 32'hC0DE_0000 | 32'(b_if.msg_rd_addr);

    always @(negedge clk) begin : mon_a
        wr_t e;
        if (a_if.ram_we === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_write got addr=%h din=%h exp no write", a_if.ram_addr, a_if.ram_din);
            end else begin
                e = qa.pop_front();
                if (a_if.ram_addr !== e.addr || a_if.ram_din !== e.data) begin
                    errors++;
                    $display("FAIL a_write got addr=%h din=%h exp addr=%h din=%h",
                             a_if.ram_addr, a_if.ram_din, e.addr, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        wr_t e;
        if (b_if.ram_we === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_write got addr=%h din=%h exp no write", b_if.ram_addr, b_if.ram_din);
            end else begin
                e = qb.pop_front();
                if (b_if.ram_addr !== e.addr || b_if.ram_din !== e.data) begin
                    errors++;
                    $display("FAIL b_write got addr=%h din=%h exp addr=%h din=%h",
                             b_if.ram_addr, b_if.ram_din, e.addr, e.data);
                end
            end
        end
    end

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({a_if.ram_we, a_if.ram_addr, a_if.ram_din, a_if.msg_rd_addr, a_if.init_done,
             a_if.data_receive, a_if.drop_cnt} !== 62'd0) begin
            errors++;
            $display("FAIL reset_values got we=%b addr=%h din=%h rd=%h done=%b rcv=%b drop=%0d exp all zero",
                     a_if.ram_we, a_if.ram_addr, a_if.ram_din, a_if.msg_rd_addr, a_if.init_done,
                     a_if.data_receive, a_if.drop_cnt);
        end
        checks++;
        if (a_if.tx_data_length !== 16'd28 || a_if.tx_total_length !== 16'd48) begin
            errors++;
            $display("FAIL reset_lengths got %0d/%0d exp 28/48", a_if.tx_data_length, a_if.tx_total_length);
        end
    endtask

    task automatic test_init;
        logic exp_we;
        for (int k = 0; k < 5; k++) qa.push_back(wr_t'{addr: 9'(1 + k), data: rom_a[k]});
        @(negedge clk);
        rst_a = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            exp_we = (cyc >= 2) && (cyc <= 6);
            checks++;
            if (a_if.ram_we !== exp_we) begin
                errors++;
                $display("FAIL init_we_cycle%0d got %b exp %b", cyc, a_if.ram_we, exp_we);
            end
            checks++;
            if (a_if.init_done !== (cyc == 7)) begin
                errors++;
                $display("FAIL init_done_cycle%0d got %b exp %b", cyc, a_if.init_done, (cyc == 7));
            end
        end
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL init_missing_writes got %0d pending exp 0", qa.size());
        end
        checks++;
        if (a_if.tx_data_length !== 16'd28 || a_if.tx_total_length !== 16'd48 || a_if.data_receive !== 1'b0) begin
            errors++;
            $display("FAIL init_lengths got %0d/%0d rcv=%b exp 28/48 rcv=0",
                     a_if.tx_data_length, a_if.tx_total_length, a_if.data_receive);
        end
    endtask

    task automatic test_rx_forward;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            a_if.rx_wr_en   = 1'b1;
            a_if.rx_wr_addr = 9'(16 + i);
            a_if.rx_wr_data = d;
            qa.push_back(wr_t'{addr: 9'(16 + i), data: d});
            @(negedge clk);
            checks++;
            if (a_if.ram_we !== 1'b1) begin
                errors++;
                $display("FAIL fwd_we_beat%0d got %b exp 1", i, a_if.ram_we);
            end
        end
        a_if.rx_wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (a_if.ram_we !== 1'b0 || qa.size() != 0) begin
            errors++;
            $display("FAIL fwd_end got we=%b pending=%0d exp we=0 pending=0", a_if.ram_we, qa.size());
        end
        a_if.rx_pkt_done     = 1'b1;
        a_if.rx_data_length  = 16'd40;
        a_if.rx_total_length = 16'd60;
        @(negedge clk);
        a_if.rx_pkt_done = 1'b0;
        checks++;
        if (a_if.tx_data_length !== 16'd40 || a_if.tx_total_length !== 16'd60 || a_if.data_receive !== 1'b1) begin
            errors++;
            $display("FAIL pkt_done_latch got %0d/%0d rcv=%b exp 40/60 rcv=1",
                     a_if.tx_data_length, a_if.tx_total_length, a_if.data_receive);
        end
        checks++;
        if (a_if.drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL fwd_drop_cnt got %0d exp 0", a_if.drop_cnt);
        end
    endtask

    task automatic test_drop_saturate;
        for (int k = 0; k < 300; k++) qb.push_back(wr_t'{addr: 9'(1 + k), data: 32'hC0DE_0000 | 32'(k)});
        b_if.rx_wr_en   = 1'b1;
        b_if.rx_wr_addr = 9'h1FF;
        b_if.rx_wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_b = 1'b0;
        for (int e = 1; e <= 300; e++) begin
            @(negedge clk);
            if (e == 100 || e == 255) begin
                checks++;
                if (b_if.drop_cnt !== 8'(e)) begin
                    errors++;
                    $display("FAIL drop_cnt_at%0d got %0d exp %0d", e, b_if.drop_cnt, e);
                end
            end
        end
        b_if.rx_wr_en = 1'b0;
        checks++;
        if (b_if.drop_cnt !== 8'd255 || b_if.init_done !== 1'b0) begin
            errors++;
            $display("FAIL drop_saturate got %0d done=%b exp 255 done=0", b_if.drop_cnt, b_if.init_done);
        end
        for (int i = 0; i < 20 && b_if.init_done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (b_if.init_done !== 1'b1 || qb.size() != 0) begin
            errors++;
            $display("FAIL b_init_complete got done=%b pending=%0d exp done=1 pending=0", b_if.init_done, qb.size());
        end
        checks++;
        if (b_if.drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL drop_hold got %0d exp 255", b_if.drop_cnt);
        end
    endtask

    task automatic test_reload_busy;
        logic [31:0] d;
        // Reload arrives mid-packet: the packet keeps flowing into the RAM.
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            a_if.rx_busy    = 1'b1;
            a_if.rx_wr_en   = 1'b1;
            a_if.rx_wr_addr = 9'(32 + i);
            a_if.rx_wr_data = d;
            a_if.reload     = (i == 0);
            a_if.rx_pkt_done     = (i == 1);
            a_if.rx_data_length  = 16'd50;
            a_if.rx_total_length = 16'd70;
            qa.push_back(wr_t'{addr: 9'(32 + i), data: d});
            @(negedge clk);
            checks++;
            if (a_if.ram_we !== 1'b1 || a_if.init_done !== 1'b1) begin
                errors++;
                $display("FAIL wait_idle_fwd_beat%0d got we=%b done=%b exp we=1 done=1", i, a_if.ram_we, a_if.init_done);
            end
        end
        a_if.reload      = 1'b0;
        a_if.rx_pkt_done = 1'b0;
        checks++;
        if (a_if.tx_data_length !== 16'd50 || a_if.tx_total_length !== 16'd70) begin
            errors++;
            $display("FAIL wait_idle_pkt_done got %0d/%0d exp 50/70", a_if.tx_data_length, a_if.tx_total_length);
        end
        a_if.rx_wr_en = 1'b0;
        a_if.rx_busy  = 1'b0;
        for (int k = 0; k < 5; k++) qa.push_back(wr_t'{addr: 9'(1 + k), data: rom_a[k]});
        @(negedge clk);
        checks++;
        if (a_if.init_done !== 1'b0 || a_if.data_receive !== 1'b0 || a_if.ram_we !== 1'b0 ||
            a_if.tx_data_length !== 16'd28 || a_if.tx_total_length !== 16'd48) begin
            errors++;
            $display("FAIL rearm_after_idle got done=%b rcv=%b we=%b len=%0d/%0d exp 0 0 0 28/48",
                     a_if.init_done, a_if.data_receive, a_if.ram_we, a_if.tx_data_length, a_if.tx_total_length);
        end
        @(negedge clk);
        checks++;
        if (a_if.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rearm_gap got we=%b exp 0", a_if.ram_we);
        end
        @(negedge clk);
        checks++;
        if (a_if.ram_we !== 1'b1 || a_if.ram_addr !== 9'd1) begin
            errors++;
            $display("FAIL rearm_first_write got we=%b addr=%h exp we=1 addr=001", a_if.ram_we, a_if.ram_addr);
        end
        a_if.reload = 1'b1;  // must be ignored during INIT
        @(negedge clk);
        a_if.reload = 1'b0;
        for (int i = 0; i < 20 && a_if.init_done !== 1'b1; i++) @(negedge clk);
        repeat (15) @(negedge clk);
        checks++;
        if (a_if.init_done !== 1'b1 || qa.size() != 0) begin
            errors++;
            $display("FAIL reload_ignored got done=%b pending=%0d exp done=1 pending=0", a_if.init_done, qa.size());
        end
    endtask

    task automatic test_reload_pkt_done_same;
        for (int k = 0; k < 5; k++) qa.push_back(wr_t'{addr: 9'(1 + k), data: rom_a[k]});
        a_if.reload          = 1'b1;
        a_if.rx_pkt_done     = 1'b1;
        a_if.rx_data_length  = 16'd40;
        a_if.rx_total_length = 16'd60;
        @(negedge clk);
        a_if.reload      = 1'b0;
        a_if.rx_pkt_done = 1'b0;
        checks++;
        if (a_if.tx_data_length !== 16'd28 || a_if.tx_total_length !== 16'd48 ||
            a_if.data_receive !== 1'b0 || a_if.init_done !== 1'b0) begin
            errors++;
            $display("FAIL reload_wins got %0d/%0d rcv=%b done=%b exp 28/48 rcv=0 done=0",
                     a_if.tx_data_length, a_if.tx_total_length, a_if.data_receive, a_if.init_done);
        end
        for (int i = 0; i < 20 && a_if.init_done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (a_if.init_done !== 1'b1 || qa.size() != 0) begin
            errors++;
            $display("FAIL reload_wins_rewrite got done=%b pending=%0d exp done=1 pending=0", a_if.init_done, qa.size());
        end
    endtask

    task automatic test_reset_mid_init;
        logic exp_we;
        // Only the first two rewrite words land before the reset hits.
        for (int k = 0; k < 2; k++) qa.push_back(wr_t'{addr: 9'(1 + k), data: rom_a[k]});
        a_if.reload = 1'b1;
        @(negedge clk);
        a_if.reload = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (a_if.ram_we !== 1'b1 || a_if.ram_addr !== 9'd3) begin
            errors++;
            $display("FAIL third_write_present got we=%b addr=%h exp we=1 addr=003", a_if.ram_we, a_if.ram_addr);
        end
        rst_a = 1'b1;
        #1;
        checks++;
        if (a_if.ram_we !== 1'b0 || a_if.init_done !== 1'b0 || a_if.msg_rd_addr !== 9'd0) begin
            errors++;
            $display("FAIL async_reset got we=%b done=%b rd=%h exp 0 0 000", a_if.ram_we, a_if.init_done, a_if.msg_rd_addr);
        end
        @(negedge clk);
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL pre_reset_writes got %0d pending exp 0", qa.size());
        end
        for (int k = 0; k < 5; k++) qa.push_back(wr_t'{addr: 9'(1 + k), data: rom_a[k]});
        rst_a = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            exp_we = (cyc >= 2) && (cyc <= 6);
            checks++;
            if (a_if.ram_we !== exp_we || a_if.init_done !== (cyc == 7)) begin
                errors++;
                $display("FAIL restart_cycle%0d got we=%b done=%b exp we=%b done=%b",
                         cyc, a_if.ram_we, a_if.init_done, exp_we, (cyc == 7));
            end
        end
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL restart_writes got %0d pending exp 0", qa.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rom_a[0] = "HELL";
        rom_a[1] = "O AL";
        rom_a[2] = "INX ";
        rom_a[3] = "AX71";
        rom_a[4] = "03\r\n";
        rst_a = 1'b0;
        rst_b = 1'b0;
        a_if.reload = 1'b0; a_if.rx_busy = 1'b0; a_if.rx_wr_en = 1'b0;
        a_if.rx_wr_addr = '0; a_if.rx_wr_data = '0; a_if.rx_pkt_done = 1'b0;
        a_if.rx_data_length = '0; a_if.rx_total_length = '0;
        b_if.reload = 1'b0; b_if.rx_busy = 1'b0; b_if.rx_wr_en = 1'b0;
        b_if.rx_wr_addr = '0; b_if.rx_wr_data = '0; b_if.rx_pkt_done = 1'b0;
        b_if.rx_data_length = '0; b_if.rx_total_length = '0;
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        test_reset();
        test_init();
        test_rx_forward();
        test_drop_saturate();
        test_reload_busy();
        test_reload_pkt_done_same();
        test_reset_mid_init();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
